// File: rtl/trace_capture_buf.sv
// trace_capture_buf
// Captures time-stamped probe snapshots into a circular record buffer once an
// armed emulation-time trigger fires, then drains them oldest-first over a
// valid/ready stream. Lives in the emu_clk domain.
//
// Optional feature macro: TRACE_STALL_ON_FULL_EN
//   Defined   - streaming drain during capture; a full buffer freezes
//               emulation time through dt_req_stall instead of ending capture.
//   Undefined - capture ends when the buffer fills; dt_req_stall is all ones.
module trace_capture_buf #(
    parameter int N_PROBES    = 8,
    parameter int PROBE_WIDTH = 25,
    parameter int N_DIG       = 1,
    parameter int TIME_WIDTH  = 64,
    parameter int DEPTH       = 1024,
    parameter int DT_WIDTH    = 32
) (
    input  logic                                          emu_clk,
    input  logic                                          emu_rst,
    input  logic [TIME_WIDTH-1:0]                         emu_time,
    input  logic                                          emu_dec_cmp,
    input  logic [N_PROBES*PROBE_WIDTH-1:0]               probe_data,
    input  logic [N_DIG-1:0]                              digital_probe,
    input  logic                                          arm,
    input  logic                                          stop,
    input  logic [TIME_WIDTH-1:0]                         trig_time,
    output logic [1:0]                                    state_out,
    output logic [$clog2(DEPTH):0]                        rec_count,
    output logic                                          overflow,
    output logic                                          rd_valid,
    input  logic                                          rd_ready,
    output logic [TIME_WIDTH+N_DIG+N_PROBES*PROBE_WIDTH-1:0] rd_data,
    output logic [DT_WIDTH-1:0]                           dt_req_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = N_PROBES * PROBE_WIDTH;
    localparam int RW = TIME_WIDTH + N_DIG + PW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic [TIME_WIDTH-1:0] trig_latched;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [RW-1:0]         mem [DEPTH];

    logic                  full;
    logic                  trig_hit;
    logic                  capture_window;
    logic                  wr_en;
    logic                  drop;
    logic                  rd_fire;
    logic [CW-1:0]         count_next;

    // Write/read qualification; the trigger cycle itself is a capture cycle
    // unless arm or stop takes priority in ARMED.
    always_comb begin
        full           = (rec_count == CW'(DEPTH));
        trig_hit       = (emu_time >= trig_latched);
        capture_window = (state == CAPTURE) ||
                         ((state == ARMED) && trig_hit && !arm && !stop);
        wr_en          = capture_window && emu_dec_cmp && !full;
        drop           = capture_window && emu_dec_cmp && full;
`ifdef TRACE_STALL_ON_FULL_EN
        rd_valid       = (rec_count != '0) && ((state == DONE) || (state == CAPTURE));
`else
        rd_valid       = (rec_count != '0) && (state == DONE);
`endif
        rd_fire        = rd_valid && rd_ready;
        count_next     = rec_count + CW'(wr_en) - CW'(rd_fire);
    end

    // Control FSM together with buffer pointers, occupancy and sticky overflow.
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state        <= IDLE;
            trig_latched <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rec_count    <= '0;
            overflow     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            rec_count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        trig_latched <= trig_time;
                        overflow     <= 1'b0;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        rec_count    <= '0;
                        state        <= ARMED;
                    end
                end
                ARMED: begin
                    if (arm) begin
                        trig_latched <= trig_time;
                    end else if (stop) begin
                        state <= IDLE;
                    end else if (trig_hit) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
`ifdef TRACE_STALL_ON_FULL_EN
                    if (stop) begin
                        state <= DONE;
                    end
`else
                    if (stop || (count_next == CW'(DEPTH))) begin
                        state <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (arm) begin
                        trig_latched <= trig_time;
                        overflow     <= 1'b0;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        rec_count    <= '0;
                        state        <= ARMED;
                    end else if ((rec_count == '0) ||
                                 (rd_fire && (rec_count == CW'(1)))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Record storage; contents need no reset because reads are masked by rd_valid.
    always_ff @(posedge emu_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {emu_time, digital_probe, probe_data};
        end
    end

    assign state_out = state;
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

`ifdef TRACE_STALL_ON_FULL_EN
    assign dt_req_stall = ((state == CAPTURE) && full) ? '0 : '1;
`else
    assign dt_req_stall = '1;
`endif

endmodule

// File: tb/tb_trace_capture_buf.sv
// tb_trace_capture_buf
// Directed bench for trace_capture_buf with DEPTH=4. Define
// TRACE_STALL_ON_FULL_EN for both RTL and bench to exercise the stall feature.
module tb_trace_capture_buf;

    localparam int N_PROBES    = 8;
    localparam int PROBE_WIDTH = 25;
    localparam int N_DIG       = 1;
    localparam int TIME_WIDTH  = 64;
    localparam int DEPTH       = 4;
    localparam int DT_WIDTH    = 32;
    localparam int PW          = N_PROBES * PROBE_WIDTH;
    localparam int RW          = TIME_WIDTH + N_DIG + PW;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic                   emu_clk = 1'b0;
    logic                   emu_rst;
    logic [TIME_WIDTH-1:0]  emu_time;
    logic                   emu_dec_cmp;
    logic [PW-1:0]          probe_data;
    logic [N_DIG-1:0]       digital_probe;
    logic                   arm;
    logic                   stop;
    logic [TIME_WIDTH-1:0]  trig_time;
    logic [1:0]             state_out;
    logic [CW-1:0]          rec_count;
    logic                   overflow;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [RW-1:0]          rd_data;
    logic [DT_WIDTH-1:0]    dt_req_stall;

    logic [PROBE_WIDTH-1:0] rd_ch0;
    logic [TIME_WIDTH-1:0]  rd_time;
    logic                   rd_dig;

    int checks = 0;
    int errors = 0;

    assign rd_ch0  = rd_data[PROBE_WIDTH-1:0];
    assign rd_time = rd_data[RW-1 -: TIME_WIDTH];
    assign rd_dig  = rd_data[PW];

    trace_capture_buf #(
        .N_PROBES   (N_PROBES),
        .PROBE_WIDTH(PROBE_WIDTH),
        .N_DIG      (N_DIG),
        .TIME_WIDTH (TIME_WIDTH),
        .DEPTH      (DEPTH),
        .DT_WIDTH   (DT_WIDTH)
    ) dut (
        .emu_clk      (emu_clk),
        .emu_rst      (emu_rst),
        .emu_time     (emu_time),
        .emu_dec_cmp  (emu_dec_cmp),
        .probe_data   (probe_data),
        .digital_probe(digital_probe),
        .arm          (arm),
        .stop         (stop),
        .trig_time    (trig_time),
        .state_out    (state_out),
        .rec_count    (rec_count),
        .overflow     (overflow),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .dt_req_stall (dt_req_stall)
    );

    // Free-running emulation clock, 10 time units per cycle.
    always #5 emu_clk = ~emu_clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic set_probes(input logic [PROBE_WIDTH-1:0] ch0);
        probe_data = '0;
        for (int k = 0; k < N_PROBES; k++) begin
            probe_data[k*PROBE_WIDTH +: PROBE_WIDTH] = ch0 + PROBE_WIDTH'(k * 1000);
        end
    endtask

    task automatic arm_dut(input logic [TIME_WIDTH-1:0] t);
        emu_dec_cmp = 1'b0;
        arm         = 1'b1;
        trig_time   = t;
        tick();
        arm         = 1'b0;
    endtask

    task automatic test_reset();
        emu_rst = 1'b1;
        tick();
        tick();
        emu_rst = 1'b0;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d want=0", state_out); end
        checks++; if (rec_count !== '0) begin errors++; $display("[TB] FAIL reset_count got=%0d want=0", rec_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got=%b want=0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("[TB] FAIL reset_rd_data got=%h want=0", rd_data); end
        checks++; if (dt_req_stall !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_dt got=%h want=ffffffff", dt_req_stall); end
    endtask

    task automatic test_trigger();
        emu_time = '0;
        arm_dut(64'd100);
        checks++; if (state_out !== 2'd1) begin errors++; $display("[TB] FAIL trig_armed got=%0d want=1", state_out); end
        for (int t = 0; t < 110; t++) begin
            emu_time         = TIME_WIDTH'(t);
            emu_dec_cmp      = (t % 4 == 0);
            digital_probe[0] = ((t / 4) % 2 == 1);
            set_probes(PROBE_WIDTH'(t));
            tick();
            if (t == 99) begin
                checks++; if (state_out !== 2'd1) begin errors++; $display("[TB] FAIL trig_t99_state got=%0d want=1", state_out); end
                checks++; if (rec_count !== '0) begin errors++; $display("[TB] FAIL trig_t99_count got=%0d want=0", rec_count); end
            end
            if (t == 100) begin
                checks++; if (state_out !== 2'd2) begin errors++; $display("[TB] FAIL trig_t100_state got=%0d want=2", state_out); end
                checks++; if (rec_count !== CW'(1)) begin errors++; $display("[TB] FAIL trig_t100_count got=%0d want=1", rec_count); end
            end
        end
        emu_dec_cmp = 1'b0;
        stop        = 1'b1;
        tick();
        stop        = 1'b0;
        checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL trig_done_state got=%0d want=3", state_out); end
        checks++; if (rec_count !== CW'(3)) begin errors++; $display("[TB] FAIL trig_done_count got=%0d want=3", rec_count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL trig_rd_valid%0d got=%b want=1", i, rd_valid); end
            checks++; if (rd_time !== TIME_WIDTH'(100 + 4 * i)) begin errors++; $display("[TB] FAIL trig_rd_time%0d got=%0d want=%0d", i, rd_time, 100 + 4 * i); end
            checks++; if (rd_dig !== (i % 2 == 0)) begin errors++; $display("[TB] FAIL trig_rd_dig%0d got=%b want=%b", i, rd_dig, (i % 2 == 0)); end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL trig_idle got=%0d want=0", state_out); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL trig_idle_valid got=%b want=0", rd_valid); end
    endtask

    task automatic test_fill_to_depth();
        emu_time = 64'd1000;
        arm_dut(64'd0);
        for (int i = 1; i <= 5; i++) begin
            emu_time    = TIME_WIDTH'(1000 + i);
            emu_dec_cmp = 1'b1;
            set_probes(PROBE_WIDTH'(i));
            tick();
            if (i == 4) begin
                checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL fill_done_state got=%0d want=3", state_out); end
            end
        end
        emu_dec_cmp = 1'b0;
        checks++; if (rec_count !== CW'(4)) begin errors++; $display("[TB] FAIL fill_count got=%0d want=4", rec_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_overflow got=%b want=0", overflow); end
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL fill_rd_valid%0d got=%b want=1", i, rd_valid); end
            checks++; if (rd_ch0 !== PROBE_WIDTH'(i)) begin errors++; $display("[TB] FAIL fill_rd_ch0_%0d got=%0d want=%0d", i, rd_ch0, i); end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL fill_idle got=%0d want=0", state_out); end
        checks++; if (rec_count !== '0) begin errors++; $display("[TB] FAIL fill_empty got=%0d want=0", rec_count); end
    endtask

    task automatic test_handshake();
        int pat[5]     = '{1, 0, 0, 1, 1};
        int exp_cnt[5] = '{2, 2, 2, 1, 0};
        int exp_ch0[5] = '{12, 12, 12, 13, 0};
        emu_time = 64'd2000;
        arm_dut(64'd0);
        for (int i = 0; i < 3; i++) begin
            emu_dec_cmp = 1'b1;
            set_probes(PROBE_WIDTH'(11 + i));
            tick();
        end
        emu_dec_cmp = 1'b0;
        stop        = 1'b1;
        tick();
        stop        = 1'b0;
        checks++; if (rec_count !== CW'(3)) begin errors++; $display("[TB] FAIL hs_count got=%0d want=3", rec_count); end
        checks++; if (rd_ch0 !== PROBE_WIDTH'(11)) begin errors++; $display("[TB] FAIL hs_first got=%0d want=11", rd_ch0); end
        for (int k = 0; k < 5; k++) begin
            rd_ready = pat[k][0];
            tick();
            checks++; if (rec_count !== CW'(exp_cnt[k])) begin errors++; $display("[TB] FAIL hs_count%0d got=%0d want=%0d", k, rec_count, exp_cnt[k]); end
            if (exp_cnt[k] != 0) begin
                checks++; if (rd_ch0 !== PROBE_WIDTH'(exp_ch0[k])) begin errors++; $display("[TB] FAIL hs_ch0_%0d got=%0d want=%0d", k, rd_ch0, exp_ch0[k]); end
            end
        end
        rd_ready = 1'b0;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL hs_idle got=%0d want=0", state_out); end
    endtask

`ifdef TRACE_STALL_ON_FULL_EN
    task automatic test_stall();
        emu_time = 64'd5000;
        rd_ready = 1'b0;
        arm_dut(64'd0);
        for (int i = 0; i < 4; i++) begin
            emu_dec_cmp = 1'b1;
            set_probes(PROBE_WIDTH'(31 + i));
            tick();
        end
        checks++; if (rec_count !== CW'(4)) begin errors++; $display("[TB] FAIL stall_count got=%0d want=4", rec_count); end
        checks++; if (state_out !== 2'd2) begin errors++; $display("[TB] FAIL stall_state got=%0d want=2", state_out); end
        checks++; if (dt_req_stall !== '0) begin errors++; $display("[TB] FAIL stall_dt got=%h want=0", dt_req_stall); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_stream_valid got=%b want=1", rd_valid); end
        set_probes(PROBE_WIDTH'(99));
        tick();
        emu_dec_cmp = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL stall_overflow got=%b want=1", overflow); end
        checks++; if (rec_count !== CW'(4)) begin errors++; $display("[TB] FAIL stall_drop_count got=%0d want=4", rec_count); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (rec_count !== CW'(3)) begin errors++; $display("[TB] FAIL stall_drain_count got=%0d want=3", rec_count); end
        checks++; if (dt_req_stall !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL stall_release got=%h want=ffffffff", dt_req_stall); end
        emu_dec_cmp = 1'b1;
        set_probes(PROBE_WIDTH'(35));
        tick();
        emu_dec_cmp = 1'b0;
        checks++; if (rec_count !== CW'(4)) begin errors++; $display("[TB] FAIL stall_fifth got=%0d want=4", rec_count); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL stall_done got=%0d want=3", state_out); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_ch0 !== PROBE_WIDTH'(32 + i)) begin errors++; $display("[TB] FAIL stall_rd%0d got=%0d want=%0d", i, rd_ch0, 32 + i); end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL stall_idle got=%0d want=0", state_out); end
    endtask
`endif

    task automatic test_stop_then_reset();
        emu_time = 64'd3000;
        arm_dut(64'd0);
        for (int i = 0; i < 3; i++) begin
            emu_dec_cmp = 1'b1;
            stop        = (i == 2);
            set_probes(PROBE_WIDTH'(21 + i));
            tick();
        end
        emu_dec_cmp = 1'b0;
        stop        = 1'b0;
        checks++; if (state_out !== 2'd3) begin errors++; $display("[TB] FAIL stop_state got=%0d want=3", state_out); end
        checks++; if (rec_count !== CW'(3)) begin errors++; $display("[TB] FAIL stop_count got=%0d want=3", rec_count); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (rec_count !== CW'(2)) begin errors++; $display("[TB] FAIL stop_drain got=%0d want=2", rec_count); end
        checks++; if (rd_ch0 !== PROBE_WIDTH'(22)) begin errors++; $display("[TB] FAIL stop_next got=%0d want=22", rd_ch0); end
        emu_rst = 1'b1;
        tick();
        emu_rst = 1'b0;
        checks++; if (state_out !== 2'd0) begin errors++; $display("[TB] FAIL rst_state got=%0d want=0", state_out); end
        checks++; if (rec_count !== '0) begin errors++; $display("[TB] FAIL rst_count got=%0d want=0", rec_count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b want=0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow got=%b want=0", overflow); end
        checks++; if (rd_data !== '0) begin errors++; $display("[TB] FAIL rst_data got=%h want=0", rd_data); end
    endtask

    // Sequence the directed scenarios and report the totals.
    initial begin
        emu_rst       = 1'b1;
        emu_time      = '0;
        emu_dec_cmp   = 1'b0;
        probe_data    = '0;
        digital_probe = '0;
        arm           = 1'b0;
        stop          = 1'b0;
        trig_time     = '0;
        rd_ready      = 1'b0;
        test_reset();
        test_trigger();
`ifndef TRACE_STALL_ON_FULL_EN
        test_fill_to_depth();
`endif
        test_handshake();
`ifdef TRACE_STALL_ON_FULL_EN
        test_stall();
`endif
        test_stop_then_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_capture_buf.md
Name: trace_capture_buf

Overview:
- Downstream consumer of the emulator probe bus and decimation strobe; captures time-stamped probe snapshots into an on-chip record buffer.
- Capture starts on an armed emulation-time trigger. Each emu_dec_cmp strobe while capturing stores one record.
- Records are drained through a valid/ready stream toward host readout logic.
- Lives in the emu_clk domain next to the trace port and the control block.

Parameters:
- N_PROBES, 8, number of analog probe channels packed on probe_data
- PROBE_WIDTH, 25, width of each fixed-point probe value
- N_DIG, 1, number of digital probe bits
- TIME_WIDTH, 64, emulation time width
- DEPTH, 1024, record capacity (power of two, >= 4)
- DT_WIDTH, 32, width of dt_req_stall

Ports:
- emu_clk  in  1  emulation clock
- emu_rst  in  1  synchronous active-high reset
- emu_time  in  TIME_WIDTH  current emulation time
- emu_dec_cmp  in  1  decimation strobe, one-cycle pulses
- probe_data  in  N_PROBES*PROBE_WIDTH  analog probes; channel k occupies bits [k*PROBE_WIDTH +: PROBE_WIDTH]
- digital_probe  in  N_DIG  digital probes
- arm  in  1  pulse: latch trig_time, enter ARMED
- stop  in  1  pulse: end capture early
- trig_time  in  TIME_WIDTH  trigger threshold, sampled on arm
- state_out  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- rec_count  out  $clog2(DEPTH)+1  records currently held
- overflow  out  1  sticky: a strobe was dropped because the buffer was full
- rd_valid  out  1  rd_data holds a record
- rd_ready  in  1  consumer accepts record
- rd_data  out  TIME_WIDTH+N_DIG+N_PROBES*PROBE_WIDTH  record, packed as {time, digital, probes}
- dt_req_stall  out  DT_WIDTH  dt request to the time manager

Behaviour:
- Clock and reset: one clock, emu_clk. Reset emu_rst is synchronous and active-high.
- Reset values: state IDLE, rec_count 0, overflow 0, rd_valid 0, rd_data 0, dt_req_stall all ones. Latched trig_time is cleared to 0.
- Reset mid-operation discards all buffered data, including a transfer in progress. rd_valid drops on the cycle after the reset edge.
- IDLE:
  - arm -> ARMED. Latch trig_time, clear overflow, discard buffer contents.
  - stop is ignored.
- ARMED:
  - When emu_time >= latched trig_time -> CAPTURE. The comparison is unsigned; equality triggers.
  - The strobe on the triggering cycle is captured.
  - stop -> IDLE. arm re-latches trig_time and stays ARMED.
- CAPTURE:
  - Each cycle with emu_dec_cmp=1 writes {emu_time, digital_probe, probe_data} as sampled at that clock edge.
  - Write latency: rec_count increments at the following edge.
  - When rec_count reaches DEPTH, or stop is seen -> DONE.
  - stop together with emu_dec_cmp on the same cycle: the record is written, then DONE.
  - arm is ignored in CAPTURE.
  - A strobe arriving while full sets overflow. This happens only with the optional feature; without it the state is already DONE.
- DONE:
  - Records stream out oldest-first.
  - rd_valid=1 whenever rec_count>0. The transfer completes on rd_valid && rd_ready.
  - The next record is presented on the following cycle with no bubble, giving sustained 1 record/cycle.
  - rec_count decrements per transfer. When the last record transfers -> IDLE.
  - arm in DONE discards unread records -> ARMED.
  - rd_data is held stable while rd_valid && !rd_ready.
- Buffer: circular storage with read/write pointers that wrap modulo DEPTH.
  - Full is rec_count==DEPTH; empty is rec_count==0.
  - Simultaneous write and read (optional feature only) leaves rec_count unchanged.
- Without the optional feature, rd_valid is 0 outside DONE.

Optional Feature:
- Macro TRACE_STALL_ON_FULL_EN.
- Defined:
  - Streaming mode: rd_valid is also asserted in CAPTURE when rec_count>0, allowing concurrent drain.
  - Reaching DEPTH does not end capture.
  - While rec_count==DEPTH in CAPTURE, dt_req_stall=0, freezing emulation time. Otherwise dt_req_stall is all ones.
  - A strobe arriving while full (same-cycle as full detect) is dropped and sets overflow.
  - Only stop moves CAPTURE -> DONE.
- Undefined: dt_req_stall is constant all ones, and the buffer stops at full as described above.

Test Plan:
- Reset, then arm with trig_time=100. emu_time ramps 0..200 by 1, emu_dec_cmp every 4th cycle starting at emu_time=0 -> ARMED until emu_time=100; first record time=100; subsequent records at 104, 108, ...
- Capture with DEPTH=4 and 5 strobes, probes channel0=1..5 -> DONE after the 4th record, rec_count=4; readout yields channel0=1,2,3,4 in order with consecutive rd_valid; IDLE after the 4th transfer.
- Readout with rd_ready toggled 1,0,0,1 -> rd_data stable across the low cycles; exactly one rec_count decrement per handshake.
- stop asserted with emu_dec_cmp on the 3rd strobe -> 3 records held, state DONE.
- Assert emu_rst during readout with 2 records remaining -> next cycle state IDLE, rec_count=0, rd_valid=0, overflow=0.
- With TRACE_STALL_ON_FULL_EN, DEPTH=4, rd_ready=0 -> after 4 records dt_req_stall=0; raise rd_ready for 1 cycle -> dt_req_stall all ones and a 5th strobe is stored; a strobe on the full cycle sets overflow=1.
